// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for serial_adder_ctrl: command side (in_*, a, b, sub)
// and result side (out_*, sum, cout, ovf) plus the busy status flag.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    // Request source / result consumer side
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    // Adder engine side
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder slice and a registered
// carry process the operands LSB first, one bit per clock. Subtract is
// A + ~B + 1, realised by inverting B at capture and seeding the carry.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    assign w_s    = r_sha[0] ^ r_shb[0] ^ r_carry;
    assign w_c    = (r_sha[0] & r_shb[0]) | ((r_sha[0] ^ r_shb[0]) & r_carry);
    assign w_last = (r_cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, serial datapath and result latching.
    // The shifting accumulator is kept apart from the visible sum so the
    // published result stays put while the next operation runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sha   <= '0;
            r_shb   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sha   <= bus.a;
                        r_shb   <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sha   <= r_sha >> 1;
                    r_shb   <= r_shb >> 1;
                    r_carry <= w_c;
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    if (w_last) begin
                        r_sum  <= {w_s, r_acc[WIDTH-1:1]};
                        r_cout <= w_c;
                        r_ovf  <= r_carry ^ w_c;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command with out_ready high and return what the block reports.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] sum, output logic co, output logic ov,
                         output int lat, output int busy_n, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) ok = 1'b0;
        bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.a = ~a; bus.b = ~b; bus.sub = ~s;
        lat = 1;
        busy_n = 0;
        while (!bus.out_valid && lat < 30) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
        if (lat >= 30) ok = 1'b0;
        sum = bus.sum; co = bus.cout; ov = bus.ovf;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b ovf=%b, want 00 0 0",
                     bus.sum, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_add;
        logic [7:0] s; logic co, ov, ok; int lat, bn;
        do_op(8'h3C, 8'h1A, 1'b0, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || lat != 9) begin
            errors++;
            $display("FAIL add_latency: got %0d (ok=%b), want 9", lat, ok);
        end
        checks++;
        if (bn != 8) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d, want 8", bn);
        end
        checks++;
        if (s !== 8'h56 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL add_result: sum=%h cout=%b ovf=%b, want 56 0 0", s, co, ov);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_return_idle: out_valid=%b in_ready=%b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_carry_ovf;
        logic [7:0] s; logic co, ov, ok; int lat, bn;
        do_op(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || s !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL add_carry: sum=%h cout=%b ovf=%b ok=%b, want 00 1 0", s, co, ov, ok);
        end
        do_op(8'h7F, 8'h01, 1'b0, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || s !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf: sum=%h cout=%b ovf=%b ok=%b, want 80 0 1", s, co, ov, ok);
        end
    endtask

    task automatic test_sub;
        logic [7:0] s; logic co, ov, ok; int lat, bn;
        do_op(8'h05, 8'h07, 1'b1, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || s !== 8'hFE || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b ok=%b, want fe 0 0", s, co, ov, ok);
        end
        do_op(8'h80, 8'h01, 1'b1, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || s !== 8'h7F || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b ok=%b, want 7f 1 1", s, co, ov, ok);
        end
        do_op(8'h9C, 8'h00, 1'b1, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || s !== 8'h9C || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_zero: sum=%h cout=%b ovf=%b ok=%b, want 9c 1 0", s, co, ov, ok);
        end
    endtask

    task automatic test_hold;
        int n;
        int bad;
        bus.out_ready = 1'b0;
        bus.a = 8'h12; bus.b = 8'h34; bus.sub = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL hold_reach_done: out_valid never rose within %0d cycles", n);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a = 8'(8'h40 + i);
            bus.b = 8'(8'hC0 - i);
            bus.sub = i[1];
            tick();
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum !== 8'h46) begin
                bad++;
                $display("FAIL hold_stable[%0d]: in_ready=%b out_valid=%b sum=%h, want 0 1 46",
                         i, bus.in_ready, bus.out_valid, bus.sum);
            end
        end
        checks++;
        if (bad != 0) errors++;
        bus.a = 8'h01; bus.b = 8'h02; bus.sub = 1'b0; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept_after: busy=%b in_ready=%b, want 1 0", bus.busy, bus.in_ready);
        end
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'h03 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_result: out_valid=%b sum=%h cout=%b, want 1 03 0",
                     bus.out_valid, bus.sum, bus.cout);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 8'h03) begin
            errors++;
            $display("FAIL hold_retain: out_valid=%b sum=%h, want 0 03", bus.out_valid, bus.sum);
        end
    endtask

    task automatic test_reset_midrun;
        logic [7:0] s; logic co, ov, ok; int lat, bn;
        int seen;
        bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b0; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b sum=%h, want 1 0 0 00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sum);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrun_no_result: out_valid seen %0d cycles, want 0", seen);
        end
        do_op(8'h01, 8'h01, 1'b0, s, co, ov, lat, bn, ok);
        checks++;
        if (ok !== 1'b1 || s !== 8'h02 || co !== 1'b0 || ov !== 1'b0 || lat != 9) begin
            errors++;
            $display("FAIL midrun_recover: sum=%h cout=%b ovf=%b lat=%0d ok=%b, want 02 0 0 9",
                     s, co, ov, lat, ok);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b, es;
        logic       sb, eco, eov;
        logic [8:0] full;
        int         prev, n, bad_res, bad_gap;
        prev = -1;
        bad_res = 0;
        bad_gap = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            sb = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, (sb ? ~b : b)} + {8'h00, sb};
            es  = full[7:0];
            eco = full[8];
            eov = sb ? ((a[7] != b[7]) && (es[7] != a[7]))
                     : ((a[7] == b[7]) && (es[7] != a[7]));
            bus.a = a; bus.b = b; bus.sub = sb; bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 30) begin
                tick();
                n++;
            end
            if (prev >= 0 && cyc - prev != 10) begin
                bad_gap++;
                $display("FAIL b2b_spacing[%0d]: gap %0d cycles, want 10", i, cyc - prev);
            end
            prev = cyc;
            tick();
            bus.a = ~a; bus.b = ~b;
            n = 0;
            while (!bus.out_valid && n < 30) begin
                tick();
                n++;
            end
            if (bus.out_valid !== 1'b1 || bus.sum !== es || bus.cout !== eco || bus.ovf !== eov) begin
                bad_res++;
                $display("FAIL b2b_result[%0d]: %h %s %h gave sum=%h cout=%b ovf=%b, want %h %b %b",
                         i, a, sb ? "-" : "+", b, bus.sum, bus.cout, bus.ovf, es, eco, eov);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad_res != 0) errors++;
        checks++;
        if (bad_gap != 0) errors++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_carry_ovf();
        test_sub();
        test_hold();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
